// File: rtl/display_share_if.sv
// Bundle between the display requesters and the seven-segment share arbiter.
// The master drives requests, and the slave (the arbiter) drives the display and status outputs.
interface display_share_if;
    logic [2:0]  req;
    logic [47:0] req_value;
    logic [11:0] req_dots;
    logic [15:0] value;
    logic [3:0]  dots;
    logic [1:0]  owner;
    logic        owner_valid;
    logic [2:0]  done;

    modport master (
        output req, req_value, req_dots,
        input  value, dots, owner, owner_valid, done
    );

    modport slave (
        input  req, req_value, req_dots,
        output value, dots, owner, owner_valid, done
    );
endinterface

// File: rtl/display_share_arbiter.sv
// Round-robin time-sharing of one 4-digit seven-segment display among three requesters.
// Each owner keeps the display for a minimum dwell, and a blank gap separates owners.
module display_share_arbiter #(
    parameter int unsigned DWELL = 16,
    parameter int unsigned BLANK = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    display_share_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [2:0]       done_q, done_d;

    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic [2:0] owner_onehot;
    logic       others_req;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Search order ptr, ptr+1, ptr+2 (mod 3); first asserted request wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = wrap3({1'b0, ptr_q} + 3'(k));
            if (!grant_valid && bus.req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign owner_onehot = 3'b001 << owner_q;
    assign others_req   = |(bus.req & ~owner_onehot);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        done_d  = 3'b000;
        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d = StShow;
                    cnt_d   = '0;
                    owner_d = grant_idx;
                    ptr_d   = wrap3({1'b0, grant_idx} + 3'd1);
                end
            end
            StShow: begin
                // A dropped request wins over a simultaneous expiry: no done pulse.
                if (!bus.req[owner_q]) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else if (cnt_q == DwellLast) begin
                    cnt_d = '0;
                    if (others_req) begin
                        state_d = StGap;
                        done_d  = owner_onehot;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == BlankLast) begin
                    cnt_d = '0;
                    if (grant_valid) begin
                        state_d = StShow;
                        owner_d = grant_idx;
                        ptr_d   = wrap3({1'b0, grant_idx} + 3'd1);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            done_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Zero-latency pass-through of the owner's live value while showing.
    always_comb begin
        bus.value = 16'h0000;
        bus.dots  = 4'b0000;
        if (state_q == StShow) begin
            case (owner_q)
                2'd0: begin
                    bus.value = bus.req_value[15:0];
                    bus.dots  = bus.req_dots[3:0];
                end
                2'd1: begin
                    bus.value = bus.req_value[31:16];
                    bus.dots  = bus.req_dots[7:4];
                end
                2'd2: begin
                    bus.value = bus.req_value[47:32];
                    bus.dots  = bus.req_dots[11:8];
                end
                default: begin
                    bus.value = 16'h0000;
                    bus.dots  = 4'b0000;
                end
            endcase
        end
    end

    assign bus.owner       = owner_q;
    assign bus.owner_valid = (state_q == StShow);
    assign bus.done        = done_q;

endmodule

// File: doc/display_share_arbiter.md
Name: display_share_arbiter

Overview:
- Time-multiplexes the 4-digit seven-segment display driver (16-bit hex value, 4 decimal-point dots) among three requesters, e.g. main counter, status word, alert code.
- Round-robin grants with a guaranteed minimum dwell per owner and a blank gap between owners.
- Drives the driver's value/dots inputs directly.

Parameters:
- DWELL, 16, cycles an owner is shown per grant before rotation is considered (>=2).
- BLANK, 2, cycles of blank display (value=0, dots=0) between owners (>=1).
- CNT_W, 16, width of the internal dwell/blank counter; must hold max(DWELL, BLANK).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req  in  3  per-requester display request, level-sensitive, bit i = requester i
- req_value  in  48  requester i value at bits [16i+15:16i]
- req_dots  in  12  requester i dots at bits [4i+3:4i]
- value  out  16  to display driver; owner's req_value while SHOW, else 16'h0000
- dots  out  4  to display driver; owner's req_dots while SHOW, else 4'b0000
- owner  out  2  current owner index, valid only when owner_valid=1
- owner_valid  out  1  1 exactly while state is SHOW
- done  out  3  one-cycle pulse on bit owner when that owner's dwell expires and it is rotated out

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, owner=0, owner_valid=0, done=0, counter=0, rr pointer=0 (requester 0 checked first). value/dots=0.
- FSM states:
  - IDLE: display blank.
  - SHOW: counter counts 0..DWELL-1.
  - GAP: counter counts 0..BLANK-1.
- value/dots are a combinational mux from registered owner/state, so there is zero latency from req_value/req_dots changes to outputs while SHOW. Live updates from the owner pass through.
- Round-robin select: search i = ptr, ptr+1, ptr+2 (mod 3); pick the first with req[i]=1. On grant, owner<=i and ptr<=(i+1) mod 3.
- IDLE: if |req, grant at this edge and enter SHOW with counter=0. owner_valid=1 from the next cycle.
- SHOW, owner's req drops: enter GAP next edge. No done pulse; counter=0.
- SHOW, counter==DWELL-1 (expiry edge):
  - Any other requester asserted: pulse done[owner] for one cycle, enter GAP.
  - Only the owner asserted: renew, counter=0, stay SHOW, no done pulse, ptr unchanged.
- SHOW otherwise: counter++.
- Req drop and expiry on the same edge: treat as drop (no done pulse).
- GAP, counter==BLANK-1: if |req, grant via round-robin into SHOW; else go to IDLE.
- GAP otherwise: counter++.
- Uninterrupted grant: owner_valid high exactly DWELL cycles. Gap: exactly BLANK cycles of owner_valid=0.
- req_value/req_dots of non-owners are ignored.
- Reset mid-SHOW or mid-GAP: next cycle outputs are at reset values, no done pulse, and ptr returns to 0.
- Counter wrap is impossible by construction; counter resets on every state entry.

Test Plan:
- Reset, req=0 -> value=16'h0000, dots=0, owner_valid=0 indefinitely.
- Single requester: req=3'b010, req_value[31:16]=16'h1234, dots=4'b1000 -> owner=1 one cycle later. value=16'h1234 continuously across renewals, never blank, done never pulses.
- Rotation: req=3'b111, values 16'h0001/16'h0123/16'h89ab -> the display sequence per cycle is:
  - owner 0 for 16 cycles, done=3'b001 pulse, 2 blank cycles;
  - owner 1 for 16 cycles, done=3'b010 pulse, 2 blank cycles;
  - owner 2 for 16 cycles, done=3'b100 pulse, 2 blank cycles;
  - back to owner 0.
- Early release: owner 2 drops req at SHOW cycle 5 with req[0] pending -> GAP of 2 cycles with no done pulse, then owner 0. With no other req pending -> IDLE after the gap.
- Live update: during owner 0 SHOW, change req_value[15:0] 16'h5678 -> 16'h789a -> value follows in the same cycle. Changing req_value of a non-owner has no effect.
- Reset mid-SHOW at counter 7 with req=3'b110 -> next cycle owner_valid=0 and value=0. After release, requester 1 is granted first (ptr=0 search finds 1).
